// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared state encoding, opcodes and pipeline depth for the CPU pipeline
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] SLTI  = 6'h0a;
  localparam logic [5:0] ORI   = 6'h0d;
  localparam logic [5:0] LUI   = 6'h0f;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2b;

  localparam int STAGES_DEFAULT = 5;

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// rtl/pipeline_hazard_sequencer_if.sv - hazard inputs and pipeline-register controls of the sequencer
interface pipeline_hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             IDStall;
  logic             EXStall;
  logic             branch_taken;
  logic             jump;
  logic             halt;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             wb_en;
  logic             halted;
  logic             watchdog;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  IDStall, EXStall, branch_taken, jump, halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble,
           wb_en, halted, watchdog, stall_cycles, flush_count
  );

  modport slave (
    output IDStall, EXStall, branch_taken, jump, halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble,
           wb_en, halted, watchdog, stall_cycles, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// rtl/pipeline_hazard_sequencer.sv - pipeline fill/run/drain/halt sequencing with stall and redirect control
module pipeline_hazard_sequencer
  import cpu_pipe_pkg::*;
#(
  parameter int STAGES    = STAGES_DEFAULT,
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  pipeline_hazard_sequencer_if.master bus
);

  localparam int PW = $clog2(STAGES) + 1;
  localparam int RW = $clog2(MAX_STALL + 1);
  localparam logic [PW-1:0] FILL_LAST  = PW'(STAGES - 2);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(STAGES - 3);
  localparam logic [RW-1:0] RUN_TRIP   = RW'(MAX_STALL - 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(MAX_STALL);

  pipe_state_t     state, state_nxt;
  logic [PW-1:0]   phase_cnt, phase_nxt;
  logic [RW-1:0]   run_cnt;
  logic            watchdog;
  logic            stalled;
  logic            pc_en, ifid_en, ifid_flush, idex_en;
  logic            idex_bubble, exmem_bubble, wb_en, halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      phase_cnt <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase_cnt;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    wb_en        = 1'b0;
    halted       = 1'b0;
    case (state)
      FILL: begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        phase_nxt = phase_cnt + PW'(1);
        if (phase_cnt == FILL_LAST) begin
          state_nxt = RUN;
          phase_nxt = '0;
        end
      end
      RUN: begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
        wb_en   = 1'b1;
        if (bus.EXStall) begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
        end else if (bus.IDStall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end else if (bus.branch_taken || bus.jump) begin
          // A redirect squashes the IF/ID slot, so a halt seen alongside it is not real.
          ifid_flush = 1'b1;
        end else if (bus.halt) begin
          ifid_flush = 1'b1;
          state_nxt  = DRAIN;
          phase_nxt  = '0;
        end
      end
      DRAIN: begin
        idex_en     = 1'b1;
        idex_bubble = 1'b1;
        wb_en       = 1'b1;
        phase_nxt   = phase_cnt + PW'(1);
        if (phase_cnt == DRAIN_LAST) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = FILL;
        phase_nxt = '0;
      end
    endcase
  end

  assign stalled = (state == RUN) && (bus.IDStall || bus.EXStall);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt  <= '0;
      watchdog <= 1'b0;
    end else begin
      if (!stalled) begin
        run_cnt <= '0;
      end else if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + RW'(1);
      end
      if (stalled && (run_cnt >= RUN_TRIP)) begin
        watchdog <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stalled),
    .count   (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ifid_flush),
    .count   (flush_count)
  );

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.wb_en        = wb_en;
  assign bus.halted       = halted;
  assign bus.watchdog     = watchdog;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_count  = flush_count;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb/tb_pipeline_hazard_sequencer.sv - directed scoreboard bench for the hazard sequencer
module tb_pipeline_hazard_sequencer;

  localparam int CNT_W = 4;

  // Control vector order: pc_en ifid_en ifid_flush idex_en idex_bubble exmem_bubble wb_en halted
  localparam logic [7:0] C_FILL  = 8'b1101_0000;
  localparam logic [7:0] C_RUN   = 8'b1101_0010;
  localparam logic [7:0] C_EXS   = 8'b0000_0110;
  localparam logic [7:0] C_IDS   = 8'b0001_1010;
  localparam logic [7:0] C_FLUSH = 8'b1111_0010;
  localparam logic [7:0] C_DRAIN = 8'b0001_1010;
  localparam logic [7:0] C_HALT  = 8'b0000_0001;

  typedef struct packed {
    logic [7:0]       ctl;
    logic             wd;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t             sb[$];
  logic             clk = 1'b0;
  logic             reset_n;
  int               tests = 0;
  int               fails = 0;
  logic             e_wd;
  logic [CNT_W-1:0] e_stall;
  logic [CNT_W-1:0] e_flush;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_sequencer #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic drive(input logic ids, input logic exs, input logic br, input logic jp, input logic hl);
    bus.IDStall      = ids;
    bus.EXStall      = exs;
    bus.branch_taken = br;
    bus.jump         = jp;
    bus.halt         = hl;
  endtask

  task automatic expect_out(input logic [7:0] ctl);
    sb.push_back(exp_t'({ctl, e_wd, e_stall, e_flush}));
  endtask

  task automatic check(input string tag);
    exp_t       e;
    logic [7:0] obs;
    #1;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s scoreboard empty got %0d entries want 1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
             bus.idex_bubble, bus.exmem_bubble, bus.wb_en, bus.halted};
      tests++;
      assert (obs === e.ctl) else begin
        fails++;
        $error("FAIL %s ctl got %b want %b", tag, obs, e.ctl);
      end
      tests++;
      assert (bus.watchdog === e.wd) else begin
        fails++;
        $error("FAIL %s watchdog got %b want %b", tag, bus.watchdog, e.wd);
      end
      tests++;
      assert (bus.stall_cycles === e.sc) else begin
        fails++;
        $error("FAIL %s stall_cycles got %0d want %0d", tag, bus.stall_cycles, e.sc);
      end
      tests++;
      assert (bus.flush_count === e.fc) else begin
        fails++;
        $error("FAIL %s flush_count got %0d want %0d", tag, bus.flush_count, e.fc);
      end
    end
  endtask

  task automatic cyc(input logic ids, input logic exs, input logic br, input logic jp,
                     input logic hl, input logic [7:0] ctl, input string tag);
    @(negedge clk);
    drive(ids, exs, br, jp, hl);
    expect_out(ctl);
    check(tag);
  endtask

  // Release reset between edges: cycle 0 is before the first edge, wb_en rises after edge 4.
  task automatic do_fill();
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(C_FILL);
    check("fill_c0");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_FILL, "fill_c1");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, C_FILL, "fill_c2_haz_ignored");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_FILL, "fill_c3");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,  "fill_c4_run");
  endtask

  initial begin
    reset_n = 1'b0;
    e_wd    = 1'b0;
    e_stall = '0;
    e_flush = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(C_FILL);
    check("reset");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_FILL, "reset_haz");

    do_fill();

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_EXS, "exs_and_ids");
    e_stall = e_stall + 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "after_exs");

    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_FLUSH, "branch_with_halt");
    e_flush = e_flush + 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "after_branch");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FLUSH, "jump");
    e_flush = e_flush + 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "after_jump");

    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_IDS, "ids_hold");
      e_stall = e_stall + 1'b1;
    end
    e_wd = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "wd_set");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "wd_sticky");

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_IDS, "halt_deferred");
    e_stall = e_stall + 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_FLUSH, "halt");
    e_flush = e_flush + 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_DRAIN, "drain0_ids");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_DRAIN, "drain1_exs");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_DRAIN, "drain2");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_HALT, "halted");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_HALT, "halted_ids");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, C_HALT, "halted_hold");

    @(negedge clk);
    reset_n = 1'b0;
    e_wd    = 1'b0;
    e_stall = '0;
    e_flush = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(C_FILL);
    check("reset2");
    do_fill();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_FLUSH, "halt2");
    e_flush = e_flush + 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DRAIN, "drain_a");
    #2;
    reset_n = 1'b0;
    e_wd    = 1'b0;
    e_stall = '0;
    e_flush = '0;
    expect_out(C_FILL);
    check("async_reset_mid_drain");
    do_fill();

    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FLUSH, "jump_sat");
      if (e_flush != {CNT_W{1'b1}}) e_flush = e_flush + 1'b1;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "flush_sat");

    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_IDS, "stall_sat");
      if (e_stall != {CNT_W{1'b1}}) e_stall = e_stall + 1'b1;
      if (i == 7) e_wd = 1'b1;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, "stall_sat_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
